line_steer_ctrl: RTL and testbench

//  Upstream steering controller for the two-channel motor PWM stage.
//  - Samples the 3-sensor IR line array and debounces it.
//  - Runs a follow/search/halt FSM.
//  - Drives per-motor enable, speed (0..10) and direction, ramp-limited one step per tick.
//  - Outputs connect directly to the motor stage's enable/speed/forward inputs for the left and right motors.

---
 rtl/line_steer_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_line_steer_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_steer_ctrl.sv
// Purpose: IR line-follower steering controller driving the two-channel motor PWM stage.
// Latency: sensor reaches the accepted pattern after a 2-FF sync plus DEB_TICKS ticks; speeds step once per tick, starting on the tick after acceptance.
// Backpressure: none; this is a free-running control loop, and run_i=0 forces an immediate, unramped stop on the next cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; run_i drive enable (level); sensor_i {L,C,R} async line sensors;
//        l_/r_en_o motor enables, l_/r_speed_o speeds 0..MAX_SPD, l_/r_fwd_o direction (1=forward);
//        state_o 00 IDLE/01 FOLLOW/10 SEARCH/11 HALT; lost_led_o high in SEARCH or HALT. All outputs registered.
module line_steer_ctrl #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned DEB_TICKS  = 3,
  parameter int unsigned LOST_TICKS = 500,
  parameter int unsigned BASE_SPD   = 7,
  parameter int unsigned SOFT_SPD   = 4,
  parameter int unsigned SEARCH_SPD = 3,
  parameter int unsigned MAX_SPD    = 10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic [2:0] sensor_i,
  output logic       l_en_o,
  output logic [3:0] l_speed_o,
  output logic       l_fwd_o,
  output logic       r_en_o,
  output logic [3:0] r_speed_o,
  output logic       r_fwd_o,
  output logic [1:0] state_o,
  output logic       lost_led_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FOLLOW = 2'b01,
    S_SEARCH = 2'b10,
    S_HALT   = 2'b11
  } state_e;

  localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
  localparam logic [3:0]  DEB_N     = 4'(DEB_TICKS);
  localparam logic [9:0]  LOST_LAST = 10'(LOST_TICKS - 1);
  // The only targets are these constants, so clamping them here bounds every speed.
  localparam int unsigned MAX_C    = (MAX_SPD > 10) ? 10 : MAX_SPD;
  localparam logic [3:0]  BASE_T   = 4'((BASE_SPD   > MAX_C) ? MAX_C : BASE_SPD);
  localparam logic [3:0]  SOFT_T   = 4'((SOFT_SPD   > MAX_C) ? MAX_C : SOFT_SPD);
  localparam logic [3:0]  SEARCH_T = 4'((SEARCH_SPD > MAX_C) ? MAX_C : SEARCH_SPD);

  state_e      state_q, state_d;
  logic [2:0]  sync1_q, sync2_q;
  logic [19:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]  prev_q, prev_d, acc_q, acc_d;
  logic [3:0]  deb_cnt_q, deb_cnt_d;
  logic [9:0]  lost_cnt_q, lost_cnt_d;
  logic        last_left_q, last_left_d;
  logic [3:0]  ftgt_l_q, ftgt_l_d, ftgt_r_q, ftgt_r_d;
  logic [3:0]  l_spd_q, l_spd_d, r_spd_q, r_spd_d;
  logic        l_fwd_q, l_fwd_d, r_fwd_q, r_fwd_d;
  logic        en_q, en_d, lost_q, lost_d;

  logic        tick, acc_hit;
  logic        dec_set, dec_dir, dec_left;
  logic [3:0]  dec_l, dec_r, tgt_l, tgt_r;
  logic        tfwd_l, tfwd_r;

  // One step toward the target. A pending direction flip first drains the
  // speed to 0, and the flip itself lands on a tick where the speed is 0.
  function automatic logic [4:0] ramp(input logic [3:0] spd, input logic fwd,
                                      input logic [3:0] tgt, input logic tfwd);
    logic [3:0] s;
    logic       f;
    s = spd;
    f = fwd;
    if (fwd != tfwd) begin
      if (spd == 4'd0) f = tfwd;
      else             s = spd - 4'd1;
    end else if (spd < tgt) begin
      s = spd + 4'd1;
    end else if (spd > tgt) begin
      s = spd - 4'd1;
    end
    return {f, s};
  endfunction

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? 20'd0 : tick_cnt_q + 20'd1;

    // Debounce: deb_cnt counts consecutive equal tick samples; 0 means no sample yet.
    prev_d    = prev_q;
    deb_cnt_d = deb_cnt_q;
    acc_hit   = 1'b0;
    if (tick) begin
      prev_d = sync2_q;
      if (deb_cnt_q != 4'd0 && sync2_q == prev_q) begin
        if (deb_cnt_q < DEB_N) deb_cnt_d = deb_cnt_q + 4'd1;
      end else begin
        deb_cnt_d = 4'd1;
      end
      acc_hit = (deb_cnt_d >= DEB_N);
    end
    acc_d = acc_hit ? sync2_q : acc_q;

    // Pattern decode for FOLLOW targets; 101 holds, 000/111 are FSM events.
    dec_set  = 1'b1;
    dec_dir  = 1'b0;
    dec_left = 1'b0;
    dec_l    = BASE_T;
    dec_r    = BASE_T;
    case (sync2_q)
      3'b010: ;
      3'b110: begin dec_l = SOFT_T; dec_dir = 1'b1; dec_left = 1'b1; end
      3'b100: begin dec_l = 4'd0;   dec_dir = 1'b1; dec_left = 1'b1; end
      3'b011: begin dec_r = SOFT_T; dec_dir = 1'b1; end
      3'b001: begin dec_r = 4'd0;   dec_dir = 1'b1; end
      default: dec_set = 1'b0;
    endcase

    state_d     = state_q;
    ftgt_l_d    = ftgt_l_q;
    ftgt_r_d    = ftgt_r_q;
    last_left_d = last_left_q;
    lost_cnt_d  = lost_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d   = S_FOLLOW;
          prev_d    = 3'd0;
          deb_cnt_d = 4'd0;
          acc_d     = 3'd0;
        end
      end
      S_FOLLOW: begin
        if (acc_hit) begin
          if (sync2_q == 3'b000)      state_d = S_SEARCH;
          else if (sync2_q == 3'b111) state_d = S_HALT;
          else if (dec_set) begin
            ftgt_l_d = dec_l;
            ftgt_r_d = dec_r;
            if (dec_dir) last_left_d = dec_left;
          end
        end
      end
      S_SEARCH: begin
        if (acc_hit && sync2_q == 3'b111) begin
          state_d = S_HALT;
        end else if (acc_hit && sync2_q != 3'b000) begin
          state_d = S_FOLLOW;
          if (dec_set) begin
            ftgt_l_d = dec_l;
            ftgt_r_d = dec_r;
            if (dec_dir) last_left_d = dec_left;
          end
        end else if (tick && acc_d == 3'b000) begin
          if (lost_cnt_q >= LOST_LAST) state_d = S_HALT;
          else                         lost_cnt_d = lost_cnt_q + 10'd1;
        end
      end
      default: ;
    endcase
    if (state_d != S_SEARCH) lost_cnt_d = 10'd0;
    if (!run_i) begin
      state_d  = S_IDLE;
      ftgt_l_d = 4'd0;
      ftgt_r_d = 4'd0;
    end

    // Targets follow the current state; SEARCH spins with the inner wheel reversed.
    tgt_l  = 4'd0;
    tgt_r  = 4'd0;
    tfwd_l = 1'b1;
    tfwd_r = 1'b1;
    case (state_q)
      S_FOLLOW: begin tgt_l = ftgt_l_q; tgt_r = ftgt_r_q; end
      S_SEARCH: begin
        tgt_l  = SEARCH_T;
        tgt_r  = SEARCH_T;
        tfwd_l = ~last_left_q;
        tfwd_r = last_left_q;
      end
      default: ;
    endcase

    l_spd_d = l_spd_q;
    l_fwd_d = l_fwd_q;
    r_spd_d = r_spd_q;
    r_fwd_d = r_fwd_q;
    if (tick) begin
      {l_fwd_d, l_spd_d} = ramp(l_spd_q, l_fwd_q, tgt_l, tfwd_l);
      {r_fwd_d, r_spd_d} = ramp(r_spd_q, r_fwd_q, tgt_r, tfwd_r);
    end
    if (!run_i) begin
      l_spd_d = 4'd0;
      r_spd_d = 4'd0;
      l_fwd_d = 1'b1;
      r_fwd_d = 1'b1;
    end

    en_d   = (state_d == S_FOLLOW) || (state_d == S_SEARCH) ||
             ((state_d == S_HALT) && (l_spd_d != 4'd0 || r_spd_d != 4'd0));
    lost_d = (state_d == S_SEARCH) || (state_d == S_HALT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      sync1_q     <= 3'd0;
      sync2_q     <= 3'd0;
      tick_cnt_q  <= 20'd0;
      prev_q      <= 3'd0;
      acc_q       <= 3'd0;
      deb_cnt_q   <= 4'd0;
      lost_cnt_q  <= 10'd0;
      last_left_q <= 1'b1;
      ftgt_l_q    <= 4'd0;
      ftgt_r_q    <= 4'd0;
      l_spd_q     <= 4'd0;
      r_spd_q     <= 4'd0;
      l_fwd_q     <= 1'b1;
      r_fwd_q     <= 1'b1;
      en_q        <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sensor_i;
      sync2_q     <= sync1_q;
      tick_cnt_q  <= tick_cnt_d;
      prev_q      <= prev_d;
      acc_q       <= acc_d;
      deb_cnt_q   <= deb_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
      last_left_q <= last_left_d;
      ftgt_l_q    <= ftgt_l_d;
      ftgt_r_q    <= ftgt_r_d;
      l_spd_q     <= l_spd_d;
      r_spd_q     <= r_spd_d;
      l_fwd_q     <= l_fwd_d;
      r_fwd_q     <= r_fwd_d;
      en_q        <= en_d;
      lost_q      <= lost_d;
    end
  end

  assign l_en_o     = en_q;
  assign r_en_o     = en_q;
  assign l_speed_o  = l_spd_q;
  assign r_speed_o  = r_spd_q;
  assign l_fwd_o    = l_fwd_q;
  assign r_fwd_o    = r_fwd_q;
  assign state_o    = state_q;
  assign lost_led_o = lost_q;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Purpose: directed bench for line_steer_ctrl with TICK_DIV=4, DEB_TICKS=2, LOST_TICKS=8.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_line_steer_ctrl;
  logic       clk = 1'b0;
  logic       rst_n, run;
  logic [2:0] sensor;
  logic       l_en, l_fwd, r_en, r_fwd, lost_led;
  logic [3:0] l_spd, r_spd;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // SEARCH/HALT profile, indexed by ticks elapsed since SEARCH was entered.
  int exp_l [13] = '{0, 0, 1, 2, 3, 3, 3, 3, 3, 2, 1, 0, 0};
  int exp_r [13] = '{7, 6, 5, 4, 3, 3, 3, 3, 3, 2, 1, 0, 0};
  int exp_en[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int exp_lf[13] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  int exp_st[13] = '{2, 2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3};

  always #5 clk = ~clk;

  line_steer_ctrl #(.TICK_DIV(4), .DEB_TICKS(2), .LOST_TICKS(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .run_i(run), .sensor_i(sensor),
    .l_en_o(l_en), .l_speed_o(l_spd), .l_fwd_o(l_fwd),
    .r_en_o(r_en), .r_speed_o(r_spd), .r_fwd_o(r_fwd),
    .state_o(state), .lost_led_o(lost_led)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      0:       obs = 32'(l_spd);
      1:       obs = 32'(r_spd);
      default: obs = 32'(state);
    endcase
  endfunction

  // Bounded wait for a change; a timeout shows up as a failed value check by the caller.
  task automatic wait_chg(input int sel, output int n);
    logic [31:0] old;
    old = obs(sel);
    n = 0;
    while (obs(sel) == old && n < 60) begin
      step(1);
      n++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_len"},   32'(l_en), 0);
    check({tag, "_ren"},   32'(r_en), 0);
    check({tag, "_lspd"},  32'(l_spd), 0);
    check({tag, "_rspd"},  32'(r_spd), 0);
    check({tag, "_lfwd"},  32'(l_fwd), 1);
    check({tag, "_rfwd"},  32'(r_fwd), 1);
    check({tag, "_lost"},  32'(lost_led), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lmin;
    int rmin;
    rst_n  = 1'b0;
    run    = 1'b0;
    sensor = 3'b000;
    step(3);
    check_reset("por");
    rst_n = 1'b1;
    step(2);

    // Ramp to 5, then reset asynchronously mid-ramp.
    run    = 1'b1;
    sensor = 3'b010;
    check("idle_pre_run", 32'(state), 0);
    step(1);
    check("follow_entry", 32'(state), 1);
    for (int s = 1; s <= 5; s++) begin
      wait_chg(0, n);
      check($sformatf("rampA_l%0d", s), 32'(l_spd), 32'(s));
    end
    rst_n = 1'b0;
    #1;
    check_reset("midramp_rst");
    step(2);
    rst_n = 1'b1;
    step(1);
    check("follow_reentry", 32'(state), 1);

    // Straight line: both wheels step 1..7, one step per tick, then hold.
    for (int s = 1; s <= 7; s++) begin
      wait_chg(0, n);
      check($sformatf("ramp_l%0d", s), 32'(l_spd), 32'(s));
      check($sformatf("ramp_r%0d", s), 32'(r_spd), 32'(s));
      if (s > 1) check($sformatf("ramp_gap%0d", s), 32'(n), 4);
    end
    step(12);
    check("hold_l", 32'(l_spd), 7);
    check("hold_r", 32'(r_spd), 7);
    check("hold_en", 32'(l_en & r_en), 1);
    check("hold_lost", 32'(lost_led), 0);

    // Hard left: left wheel drains to 0, right stays at BASE.
    sensor = 3'b100;
    for (int s = 6; s >= 0; s--) begin
      wait_chg(0, n);
      check($sformatf("left_l%0d", s), 32'(l_spd), 32'(s));
      check($sformatf("left_r%0d", s), 32'(r_spd), 7);
      if (s < 6) check($sformatf("left_gap%0d", s), 32'(n), 4);
    end
    step(8);
    check("left_l0_hold", 32'(l_spd), 0);
    check("left_lfwd", 32'(l_fwd), 1);
    check("left_state", 32'(state), 1);

    // Line lost: SEARCH spin left, then HALT after 8 lost ticks.
    sensor = 3'b000;
    wait_chg(2, n);
    check("search_entry", 32'(state), 2);
    check("search_led", 32'(lost_led), 1);
    for (int k = 0; k < 13; k++) begin
      step(k == 0 ? 2 : 4);
      check($sformatf("srch_l_k%0d", k),  32'(l_spd), 32'(exp_l[k]));
      check($sformatf("srch_r_k%0d", k),  32'(r_spd), 32'(exp_r[k]));
      check($sformatf("srch_en_k%0d", k), 32'(l_en), 32'(exp_en[k]));
      check($sformatf("srch_lf_k%0d", k), 32'(l_fwd), 32'(exp_lf[k]));
      check($sformatf("srch_rf_k%0d", k), 32'(r_fwd), 1);
      check($sformatf("srch_st_k%0d", k), 32'(state), 32'(exp_st[k]));
      check($sformatf("srch_led_k%0d", k), 32'(lost_led), 1);
    end

    // HALT ignores a line reappearing.
    sensor = 3'b010;
    step(24);
    check("halt_stay", 32'(state), 3);
    check("halt_en", 32'(l_en | r_en), 0);
    check("halt_spd", 32'(l_spd | r_spd), 0);
    run = 1'b0;
    step(1);
    check("halt_exit", 32'(state), 0);
    check("halt_exit_led", 32'(lost_led), 0);

    // Back to 7/7 for the glitch tests.
    run = 1'b1;
    n = 0;
    while (!(l_spd == 4'd7 && r_spd == 4'd7) && n < 120) begin
      step(1);
      n++;
    end
    check("reramp_l", 32'(l_spd), 7);
    check("reramp_r", 32'(r_spd), 7);

    // A 4-cycle glitch is seen by exactly one tick: never accepted.
    sensor = 3'b110;
    step(4);
    sensor = 3'b010;
    lmin = 15;
    rmin = 15;
    repeat (32) begin
      step(1);
      if (l_spd < lmin) lmin = l_spd;
      if (r_spd < rmin) rmin = r_spd;
    end
    check("glitch1_lmin", 32'(lmin), 7);
    check("glitch1_rmin", 32'(rmin), 7);
    check("glitch1_state", 32'(state), 1);

    // An 8-cycle pattern spans two ticks and is accepted: left dips 7->6->5, then recovers.
    sensor = 3'b110;
    lmin = 15;
    rmin = 15;
    repeat (8) begin
      step(1);
      if (l_spd < lmin) lmin = l_spd;
      if (r_spd < rmin) rmin = r_spd;
    end
    sensor = 3'b010;
    repeat (40) begin
      step(1);
      if (l_spd < lmin) lmin = l_spd;
      if (r_spd < rmin) rmin = r_spd;
    end
    check("glitch2_lmin", 32'(lmin), 5);
    check("glitch2_rmin", 32'(rmin), 7);
    check("glitch2_recover", 32'(l_spd), 7);

    // Safety stop from 7/7: one cycle, no ramp.
    run = 1'b0;
    check("stop_pre", 32'(l_spd), 7);
    step(1);
    check("stop_state", 32'(state), 0);
    check("stop_lspd", 32'(l_spd), 0);
    check("stop_rspd", 32'(r_spd), 0);
    check("stop_en", 32'(l_en | r_en), 0);
    check("stop_fwd", 32'(l_fwd & r_fwd), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
